pc_stack_unit: RTL and testbench
================================

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 Parameter ADDR_W, default 10, program-address width in bits.
REQ-002 Parameter STACK_DEPTH, default 8, return-address stack entries (>=2).
REQ-003 Parameter INTR_VEC, default ADDR_W'h3FF, interrupt vector address.
REQ-004 Clock and reset: RST synchronous, active-high; clock CLK.
REQ-005 CLK  in  1  clock, all state changes on rising edge.
REQ-006 RST  in  1  synchronous active-high reset.
REQ-007 DIN  in  ADDR_W  absolute target for PC_LD / CALL.
REQ-008 OFFSET  in  ADDR_W  two's-complement relative offset for PC_REL.
REQ-009 PC_LD  in  1  load DIN.
REQ-010 PC_REL  in  1  PC_COUNT <= PC_COUNT + OFFSET.
REQ-011 PC_INC  in  1  PC_COUNT <= PC_COUNT + 1.
REQ-012 CALL  in  1  push PC_COUNT+1, load DIN.
REQ-013 RET  in  1  pop top of stack into PC_COUNT.
REQ-014 INTR  in  1  push PC_COUNT, load INTR_VEC.
REQ-015 PC_COUNT  out  ADDR_W  current program address (registered).
REQ-016 SP  out  clog2(STACK_DEPTH+1)  occupied stack entries.
REQ-017 STK_FULL  out  1  SP == STACK_DEPTH (combinational from SP).
REQ-018 STK_EMPTY  out  1  SP == 0 (combinational from SP).
REQ-019 STK_ERR  out  1  sticky overflow/underflow flag.

Function
REQ-020 Exactly one operation SHALL execute per cycle, priority RST > INTR > RET > CALL > PC_LD > PC_REL > PC_INC; lower-priority requests in the same cycle are ignored.
REQ-021 No request asserted: PC_COUNT, SP, stack contents SHALL hold.
REQ-022 All PC arithmetic SHALL be modulo 2^ADDR_W; PC_INC at all-ones wraps to 0; PC_REL with negative OFFSET wraps below 0.
REQ-023 CALL pushed value SHALL be (PC_COUNT+1) mod 2^ADDR_W.
REQ-024 Push (CALL/INTR) SHALL write stack[SP] and increment SP; new PC visible the cycle after the request edge (1-cycle latency).
REQ-025 Pop (RET) SHALL load PC_COUNT from stack[SP-1] and decrement SP in the same edge.
REQ-026 CALL or INTR while STK_FULL: no push, PC_COUNT and SP hold, STK_ERR set.
REQ-027 RET while STK_EMPTY: PC_COUNT and SP hold, STK_ERR set.
REQ-028 STK_ERR SHALL stay 1 until RST; no other input clears it.
REQ-029 Stack storage SHALL be LIFO; entries above SP are don't-care and never observable.
REQ-030 Back-to-back push/pop on consecutive cycles SHALL work at full rate with no bubble.

Reset
REQ-031 RST=1 at a rising edge: PC_COUNT=0, SP=0, STK_ERR=0, regardless of other inputs.
REQ-032 RST mid-sequence (stack non-empty) SHALL discard all stacked entries; stack RAM contents need not be cleared.
REQ-033 Outputs after reset: STK_EMPTY=1, STK_FULL=0.

Verification
REQ-034 RST with PC_LD=1, DIN=0x155 -> PC_COUNT=0x000, SP=0, STK_ERR=0.
REQ-035 PC_LD DIN=0x3FF, then PC_INC -> 0x3FF then 0x000; PC_REL OFFSET=0x3FE from 0x005 -> 0x003.
REQ-036 PC=0x010, CALL DIN=0x200, CALL DIN=0x300, RET, RET -> PC 0x200, 0x300, 0x201, 0x011; SP 1,2,1,0.
REQ-037 PC=0x040, INTR and CALL and PC_INC same cycle -> PC=INTR_VEC, stacked 0x040, SP=1; RET -> 0x040.
REQ-038 Eight CALLs (default depth) then ninth CALL -> STK_FULL=1, ninth ignored, PC holds, STK_ERR=1 until RST.
REQ-039 RET with SP=0 -> PC holds, SP=0, STK_ERR=1; subsequent PC_INC still increments.

Source files
------------

// File: rtl/pc_stack_unit.sv
// Program counter with a hardware return-address stack. One operation per cycle,
// priority INTR > RET > CALL > PC_LD > PC_REL > PC_INC, with a sticky stack error flag.
module pc_stack_unit #(
  parameter int                ADDR_W      = 10,
  parameter int                STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] INTR_VEC    = ADDR_W'(10'h3FF)
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic [ADDR_W-1:0]                    DIN,
  input  logic [ADDR_W-1:0]                    OFFSET,
  input  logic                                 PC_LD,
  input  logic                                 PC_REL,
  input  logic                                 PC_INC,
  input  logic                                 CALL,
  input  logic                                 RET,
  input  logic                                 INTR,
  output logic [ADDR_W-1:0]                    PC_COUNT,
  output logic [$clog2(STACK_DEPTH+1)-1:0]     SP,
  output logic                                 STK_FULL,
  output logic                                 STK_EMPTY,
  output logic                                 STK_ERR
);

  localparam int SP_W  = $clog2(STACK_DEPTH+1);
  localparam int IDX_W = $clog2(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_NONE, OP_INTR, OP_RET, OP_CALL, OP_LD, OP_REL, OP_INC
  } op_e;

  op_e               op;
  logic [ADDR_W-1:0] pc_q, pc_d, push_val;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              err_q, err_d, push_en;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [ADDR_W-1:0] stk_q [STACK_DEPTH];

  assign STK_FULL  = (sp_q == SP_W'(STACK_DEPTH));
  assign STK_EMPTY = (sp_q == '0);
  assign wr_idx    = sp_q[IDX_W-1:0];
  assign rd_idx    = IDX_W'(sp_q - 1'b1);

  always_comb begin
    op = OP_NONE;
    if      (INTR)   op = OP_INTR;
    else if (RET)    op = OP_RET;
    else if (CALL)   op = OP_CALL;
    else if (PC_LD)  op = OP_LD;
    else if (PC_REL) op = OP_REL;
    else if (PC_INC) op = OP_INC;
  end

  // Stack faults leave PC and SP untouched; only the sticky flag records them.
  always_comb begin
    pc_d     = pc_q;
    sp_d     = sp_q;
    err_d    = err_q;
    push_en  = 1'b0;
    push_val = pc_q;
    case (op)
      OP_INTR: begin
        if (STK_FULL) err_d = 1'b1;
        else begin
          push_en  = 1'b1;
          push_val = pc_q;
          sp_d     = sp_q + 1'b1;
          pc_d     = INTR_VEC;
        end
      end
      OP_RET: begin
        if (STK_EMPTY) err_d = 1'b1;
        else begin
          pc_d = stk_q[rd_idx];
          sp_d = sp_q - 1'b1;
        end
      end
      OP_CALL: begin
        if (STK_FULL) err_d = 1'b1;
        else begin
          push_en  = 1'b1;
          push_val = pc_q + 1'b1;
          sp_d     = sp_q + 1'b1;
          pc_d     = DIN;
        end
      end
      OP_LD:   pc_d = DIN;
      OP_REL:  pc_d = pc_q + OFFSET;
      OP_INC:  pc_d = pc_q + 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q  <= '0;
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      sp_q  <= sp_d;
      err_q <= err_d;
    end
  end

  // Storage is not reset; entries at or above SP are never read.
  always_ff @(posedge CLK) begin
    if (push_en && !RST) stk_q[wr_idx] <= push_val;
  end

  assign PC_COUNT = pc_q;
  assign SP       = sp_q;
  assign STK_ERR  = err_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed and randomized checks of pc_stack_unit against a queue-based reference model.
module tb_pc_stack_unit;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 8;
  localparam int MASK   = (1 << ADDR_W) - 1;
  localparam int VEC    = 'h3FF;

  logic              CLK, RST;
  logic [ADDR_W-1:0] DIN, OFFSET;
  logic              PC_LD, PC_REL, PC_INC, CALL, RET, INTR;
  logic [ADDR_W-1:0] PC_COUNT;
  logic [3:0]        SP;
  logic              STK_FULL, STK_EMPTY, STK_ERR;

  int tests = 0;
  int fails = 0;

  // reference model state
  int m_pc;
  int m_stk[$];
  bit m_err;

  pc_stack_unit #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .OFFSET(OFFSET),
    .PC_LD(PC_LD), .PC_REL(PC_REL), .PC_INC(PC_INC),
    .CALL(CALL), .RET(RET), .INTR(INTR),
    .PC_COUNT(PC_COUNT), .SP(SP), .STK_FULL(STK_FULL),
    .STK_EMPTY(STK_EMPTY), .STK_ERR(STK_ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".pc"},    32'(PC_COUNT),  32'(m_pc));
    chk({tag, ".sp"},    32'(SP),        32'(m_stk.size()));
    chk({tag, ".full"},  32'(STK_FULL),  32'(m_stk.size() == DEPTH));
    chk({tag, ".empty"}, 32'(STK_EMPTY), 32'(m_stk.size() == 0));
    chk({tag, ".err"},   32'(STK_ERR),   32'(m_err));
  endtask

  function automatic void model_step(bit rst, bit intr, bit ret, bit call, bit ld,
                                     bit rel, bit inc, int din, int off);
    if (rst) begin
      m_pc = 0; m_stk.delete(); m_err = 0;
    end else if (intr) begin
      if (m_stk.size() == DEPTH) m_err = 1;
      else begin m_stk.push_back(m_pc); m_pc = VEC; end
    end else if (ret) begin
      if (m_stk.size() == 0) m_err = 1;
      else m_pc = m_stk.pop_back();
    end else if (call) begin
      if (m_stk.size() == DEPTH) m_err = 1;
      else begin m_stk.push_back((m_pc + 1) & MASK); m_pc = din; end
    end else if (ld)  m_pc = din;
    else if (rel)     m_pc = (m_pc + off) & MASK;
    else if (inc)     m_pc = (m_pc + 1) & MASK;
  endfunction

  // Drive one cycle of requests, advance the model, then check just after the edge.
  task automatic cyc(input string tag, input bit rst, input bit intr, input bit ret,
                     input bit call, input bit ld, input bit rel, input bit inc,
                     input int din = 0, input int off = 0);
    RST = rst; INTR = intr; RET = ret; CALL = call;
    PC_LD = ld; PC_REL = rel; PC_INC = inc;
    DIN = ADDR_W'(din); OFFSET = ADDR_W'(off);
    @(posedge CLK);
    model_step(rst, intr, ret, call, ld, rel, inc, din & MASK, off & MASK);
    #1;
    chk_model(tag);
  endtask

  initial begin
    RST = 1'b1; INTR = 0; RET = 0; CALL = 0; PC_LD = 0; PC_REL = 0; PC_INC = 0;
    DIN = '0; OFFSET = '0;
    m_pc = 0; m_err = 0;

    // reset overrides a simultaneous load
    cyc("rst_ld", 1, 0, 0, 0, 1, 0, 0, 'h155);
    chk("rst_pc0", 32'(PC_COUNT), 32'h000);
    chk("rst_empty", 32'(STK_EMPTY), 32'h1);

    // idle holds
    cyc("idle", 0, 0, 0, 0, 0, 0, 0, 'h123, 'h5);

    // wrap on increment and negative relative offset
    cyc("ld3ff", 0, 0, 0, 0, 1, 0, 0, 'h3FF);
    cyc("inc_wrap", 0, 0, 0, 0, 0, 0, 1);
    chk("inc_wrap_lit", 32'(PC_COUNT), 32'h000);
    cyc("ld005", 0, 0, 0, 0, 1, 0, 0, 'h005);
    cyc("rel_neg", 0, 0, 0, 0, 0, 1, 0, 0, 'h3FE);
    chk("rel_neg_lit", 32'(PC_COUNT), 32'h003);

    // nested call / return at full rate
    cyc("ld010", 0, 0, 0, 0, 1, 0, 0, 'h010);
    cyc("call1", 0, 0, 0, 1, 0, 0, 0, 'h200);
    cyc("call2", 0, 0, 0, 1, 0, 0, 0, 'h300);
    cyc("ret1",  0, 0, 1, 0, 0, 0, 0);
    chk("ret1_lit", 32'(PC_COUNT), 32'h201);
    cyc("ret2",  0, 0, 1, 0, 0, 0, 0);
    chk("ret2_lit", 32'(PC_COUNT), 32'h011);

    // interrupt wins over call and increment
    cyc("ld040", 0, 0, 0, 0, 1, 0, 0, 'h040);
    cyc("intr", 0, 1, 0, 1, 0, 0, 1, 'h111);
    chk("intr_lit", 32'(PC_COUNT), 32'h3FF);
    cyc("intr_ret", 0, 0, 1, 0, 0, 0, 0);
    chk("intr_ret_lit", 32'(PC_COUNT), 32'h040);

    // overflow
    for (int i = 0; i < DEPTH; i++) cyc("fill", 0, 0, 0, 1, 0, 0, 0, 'h20 + i * 16);
    chk("full_lit", 32'(STK_FULL), 32'h1);
    cyc("ovf_call", 0, 0, 0, 1, 0, 0, 0, 'h3AA);
    chk("ovf_err_lit", 32'(STK_ERR), 32'h1);
    cyc("ovf_intr", 0, 1, 0, 0, 0, 0, 0);
    cyc("ovf_inc", 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) cyc("drain", 0, 0, 1, 0, 0, 0, 0);
    cyc("sticky", 0, 0, 0, 0, 0, 0, 0);

    // reset mid-stack clears error and discards entries
    cyc("push_a", 0, 0, 0, 1, 0, 0, 0, 'h0AB);
    cyc("rst_mid", 1, 0, 0, 0, 0, 0, 0);
    cyc("udf_ret", 0, 0, 1, 0, 0, 0, 0);
    chk("udf_err_lit", 32'(STK_ERR), 32'h1);
    cyc("udf_inc", 0, 0, 0, 0, 0, 0, 1);
    chk("udf_inc_lit", 32'(PC_COUNT), 32'h001);
    cyc("rst2", 1, 0, 0, 0, 0, 0, 0);

    // randomized traffic, stack-heavy mix
    for (int n = 0; n < 400; n++) begin
      int r;
      bit rst, intr, ret, call, ld, rel, inc;
      r    = int'($urandom_range(0, 99));
      rst  = (r < 2);
      intr = ($urandom_range(0, 9) == 0);
      ret  = ($urandom_range(0, 2) == 0);
      call = ($urandom_range(0, 2) == 0);
      ld   = ($urandom_range(0, 3) == 0);
      rel  = ($urandom_range(0, 3) == 0);
      inc  = ($urandom_range(0, 1) == 0);
      cyc("rnd", rst, intr, ret, call, ld, rel, inc,
          int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
